// File: rtl/and_tt_pkg.sv
// Shared definitions for the truth-table exerciser: FSM state encoding and
// default sizing parameters.
package and_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned DEF_N_IN       = 2;
  localparam int unsigned DEF_SETTLE_CYC = 2;

endpackage

// File: rtl/settle_timer.sv
// Settle counter: restarts at 0 on load, counts while run is high and
// flags expired on count SETTLE_CYC-1.
module settle_timer
  import and_tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int unsigned    CW   = $clog2(SETTLE_CYC) + 1;
  localparam logic [CW-1:0]  LAST = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/and_tt_checker.sv
// Clocked truth-table exerciser: walks every input pattern of the gate under
// test, samples its output after a settle time and compares against expected.
module and_tt_checker
  import and_tt_pkg::*;
#(
  parameter int unsigned N_IN       = DEF_N_IN,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err_idx,
  output logic [2**N_IN-1:0]   observed
);

  localparam int unsigned NPAT = 2**N_IN;

  state_t            state, state_nx;
  logic [N_IN-1:0]   idx;
  logic [NPAT-1:0]   exp_q;
  logic              timer_load;
  logic              expired;
  logic              last_idx;
  logic              mismatch;

  assign last_idx = &idx;
  assign mismatch = (dut_out != exp_q[idx]);

  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .run     (state == DRIVE),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = DRIVE;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        if (expired) state_nx = SAMPLE;
      end
      SAMPLE: begin
        if (last_idx) begin
          state_nx = DONE;
        end else begin
          state_nx   = DRIVE;
          timer_load = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // done/pass/busy are registered out of the DONE cycle, so they change on
  // the edge that leaves DONE (2^N_IN*(SETTLE_CYC+1)+1 edges after start).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx           <= '0;
      exp_q         <= '0;
      dut_in        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      observed      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q         <= expected;
            err_count     <= '0;
            observed      <= '0;
            first_err_idx <= '0;
            pass          <= 1'b0;
            idx           <= '0;
            dut_in        <= '0;
            busy          <= 1'b1;
          end
        end
        SAMPLE: begin
          observed[idx] <= dut_out;
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_idx <= idx;
          end
          if (!last_idx) begin
            idx    <= idx + 1'b1;
            dut_in <= idx + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
          pass <= (err_count == '0);
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_and_tt_checker.sv
// Directed bench for and_tt_checker driving a modelled AND gate at default,
// SETTLE_CYC=1 and N_IN=3 configurations.
module tb_and_tt_checker;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  // default configuration
  logic       start0, dout0, busy0, done0, pass0;
  logic [3:0] exp0, obs0;
  logic [1:0] din0, first0;
  logic [2:0] err0;
  assign dout0 = din0[1] & din0[0];   // a = bit 1, b = bit 0

  // SETTLE_CYC = 1
  logic       start1, dout1, busy1, done1, pass1;
  logic [3:0] exp1, obs1;
  logic [1:0] din1, first1;
  logic [2:0] err1;
  assign dout1 = din1[1] & din1[0];

  // N_IN = 3, three-input AND
  logic       start2, dout2, busy2, done2, pass2;
  logic [7:0] exp2, obs2;
  logic [2:0] din2, first2;
  logic [3:0] err2;
  assign dout2 = &din2;

  and_tt_checker u0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .expected(exp0),
    .dut_out(dout0), .dut_in(din0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_idx(first0), .observed(obs0)
  );

  and_tt_checker #(.SETTLE_CYC(1)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .expected(exp1),
    .dut_out(dout1), .dut_in(din1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_idx(first1), .observed(obs1)
  );

  and_tt_checker #(.N_IN(3)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .expected(exp2),
    .dut_out(dout2), .dut_in(din2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_idx(first2), .observed(obs2)
  );

  int checks = 0;
  int errors = 0;
  int de, nd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // One default-config sweep; optionally pulses start during pattern 2 and
  // in the DONE cycle. Returns the edge index of the first done and the
  // number of done pulses seen within a 20-edge window.
  task automatic sweep0(input logic [3:0] e, input bit inject,
                        output int done_edge, output int n_done);
    done_edge = -1;
    n_done    = 0;
    @(negedge clock);
    exp0   = e;
    start0 = 1'b1;
    @(posedge clock); #1 start0 = 1'b0;
    check("u0_busy_rise", busy0, 1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1 start0 = 1'b0;
      if (inject && (k == 7 || k == 12)) start0 = 1'b1;
      if (done0) begin
        n_done++;
        if (done_edge < 0) done_edge = k;
      end
      if (k <= 11) check("u0_dut_in", din0, k / 3);
      if (k == 12) check("u0_busy_in_done", busy0, 1);
      if (k == 13) check("u0_busy_fall", busy0, 0);
    end
  endtask

  initial begin
    start0 = 0; start1 = 0; start2 = 0;
    exp0 = '0; exp1 = '0; exp2 = '0;
    #12;
    check("rst_dut_in", din0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_first", first0, 0);
    check("rst_obs", obs0, 0);
    @(negedge clock) reset_n = 1'b1;

    // AND truth table, expect clean pass
    sweep0(4'b1000, 1'b0, de, nd);
    check("and_done_edge", de, 13);
    check("and_done_count", nd, 1);
    check("and_obs", obs0, 4'b1000);
    check("and_err", err0, 0);
    check("and_first", first0, 0);
    check("and_pass", pass0, 1);

    // XOR expectation against AND gate
    sweep0(4'b0110, 1'b0, de, nd);
    check("xor_done_edge", de, 13);
    check("xor_obs", obs0, 4'b1000);
    check("xor_err", err0, 3);
    check("xor_first", first0, 1);
    check("xor_pass", pass0, 0);

    // stray start pulses during a sweep are ignored
    sweep0(4'b1000, 1'b1, de, nd);
    check("ign_done_edge", de, 13);
    check("ign_done_count", nd, 1);
    check("ign_obs", obs0, 4'b1000);
    check("ign_err", err0, 0);
    check("ign_pass", pass0, 1);

    // async reset during SAMPLE of pattern 2
    @(negedge clock);
    exp0   = 4'b1000;
    start0 = 1'b1;
    @(posedge clock); #1 start0 = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    check("pre_rst_dut_in", din0, 2);
    check("pre_rst_busy", busy0, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dut_in", din0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_pass", pass0, 0);
    check("mid_rst_err", err0, 0);
    check("mid_rst_obs", obs0, 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("post_rst_idle_busy", busy0, 0);
    sweep0(4'b1000, 1'b0, de, nd);
    check("post_rst_done_edge", de, 13);
    check("post_rst_pass", pass0, 1);
    check("post_rst_obs", obs0, 4'b1000);

    // SETTLE_CYC = 1: each pattern held two cycles
    @(negedge clock);
    exp1   = 4'b1000;
    start1 = 1'b1;
    @(posedge clock); #1 start1 = 1'b0;
    de = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (done1 && de < 0) de = k;
      if (k <= 7) check("s1_dut_in", din1, k / 2);
    end
    check("s1_done_edge", de, 9);
    check("s1_obs", obs1, 4'b1000);
    check("s1_err", err1, 0);
    check("s1_pass", pass1, 1);

    // N_IN = 3 against three-input AND
    @(negedge clock);
    exp2   = 8'h80;
    start2 = 1'b1;
    @(posedge clock); #1 start2 = 1'b0;
    de = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (done2 && de < 0) de = k;
      if (k <= 23) check("n3_dut_in", din2, k / 3);
    end
    check("n3_done_edge", de, 25);
    check("n3_obs", obs2, 8'h80);
    check("n3_err", err2, 0);
    check("n3_first", first2, 0);
    check("n3_pass", pass2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
